// File: rtl/fetch_unit.sv
// Instruction-fetch controller: owns the fetch PC, registers one word per cycle toward decode.
// Latency: word at imem_addr_o appears on instr_o after the next rising edge; redirects cost one bubble.
// Backpressure: instr_valid_o && !instr_ready_i freezes instr_o, instr_pc_o and the fetch PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        fault_o,
  output logic [31:0] fault_pc_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state;
  logic [31:0] fetch_pc;
  logic        slot_free;
  logic        target_aligned;

  // The output slot can take a new word when empty or when its current word leaves this cycle.
  assign slot_free      = !instr_valid_o || instr_ready_i;
  assign target_aligned = (redirect_pc_i[1:0] == 2'b00);
  assign imem_addr_o    = fetch_pc;

  // Control state, fetch PC and the registered output stage; redirect beats halt beats load.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= RUN;
      fetch_pc      <= RESET_PC_ALIGNED;
      instr_o       <= 32'h0;
      instr_pc_o    <= 32'h0;
      instr_valid_o <= 1'b0;
      fault_o       <= 1'b0;
      fault_pc_o    <= 32'h0;
    end else if (redirect_i) begin
      // Flush whatever is presented; a concurrent handshake has already completed this edge.
      instr_valid_o <= 1'b0;
      if (target_aligned) begin
        fetch_pc <= redirect_pc_i;
        fault_o  <= 1'b0;
        state    <= halt_i ? HALTED : RUN;
      end else begin
        // Misaligned target: park in FAULT, keep the old fetch PC, remember the bad target.
        state      <= FAULT;
        fault_o    <= 1'b1;
        fault_pc_o <= redirect_pc_i;
      end
    end else if (state == FAULT) begin
      // Only an aligned redirect or reset leaves FAULT; halt is ignored here.
      state <= FAULT;
    end else if (halt_i) begin
      // Stop fetching but let a held word drain to decode.
      state <= HALTED;
      if (instr_valid_o && instr_ready_i) begin
        instr_valid_o <= 1'b0;
      end
    end else begin
      // RUN, or HALTED with halt just dropped: fetch resumes this same edge.
      state <= RUN;
      if (slot_free) begin
        instr_o       <= imem_data_i;
        instr_pc_o    <= fetch_pc;
        instr_valid_o <= 1'b1;
        fetch_pc      <= fetch_pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, redirect, fault, halt, wrap, async reset.
// Inputs are driven 1 time unit after each rising edge; outputs are checked at the same point.
// A behavioural instruction memory returns table words at 0x0..0xC and an address-derived word elsewhere.
module tb_fetch_unit;

  logic        clk;
  logic        rstn;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fault;
  logic [31:0] fault_pc;

  int n_cmp;
  int n_err;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .halt_i        (halt),
    .fault_o       (fault),
    .fault_pc_o    (fault_pc)
  );

  // Instruction memory contents as the bench expects them.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h11;
      32'h4:   mem_word = 32'h22;
      32'h8:   mem_word = 32'h33;
      32'hC:   mem_word = 32'h44;
      default: mem_word = a ^ 32'hC0DE_0000;
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check a valid instruction at pc with its memory word.
  task automatic chk_instr(input string tag, input logic [31:0] pc);
    chk({tag, "_vld"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_dat"}, instr, mem_word(pc));
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rstn        = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;

    // Reset state
    #12;
    chk("rst_vld", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_fpc", fault_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    #6 rstn = 1'b1;   // released mid-cycle, away from the edge

    // Sequential fetch 0,4,8
    step(); chk_instr("seq0", 32'h0);
    chk("seq0_raw", instr, 32'h11);
    step(); chk_instr("seq1", 32'h4);
    step(); chk_instr("seq2", 32'h8);
    chk("seq2_raw", instr, 32'h33);

    // Backpressure: hold 3 cycles at pc 8
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_instr("bp_hold", 32'h8);
      chk("bp_addr", imem_addr, 32'hC);
    end
    instr_ready = 1'b1;
    step(); chk_instr("bp_c", 32'hC);
    chk("bp_c_raw", instr, 32'h44);
    step(); chk_instr("bp_10", 32'h10);

    // Redirect to 0x40 while handshaking: one bubble
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("rd_bubble", {31'b0, instr_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'h40);
    step(); chk_instr("rd_40", 32'h40);
    step(); chk_instr("rd_44", 32'h44);

    // Misaligned redirect -> FAULT, halt toggles ignored
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    chk("flt_o", {31'b0, fault}, 32'd1);
    chk("flt_pc", fault_pc, 32'h42);
    chk("flt_vld", {31'b0, instr_valid}, 32'd0);
    chk("flt_addr", imem_addr, 32'h48);
    for (int i = 0; i < 4; i++) begin
      halt = (i % 2 == 0);
      step();
      chk("flt_stay", {31'b0, fault}, 32'd1);
      chk("flt_novld", {31'b0, instr_valid}, 32'd0);
    end
    halt = 1'b0;
    step();
    chk("flt_novld2", {31'b0, instr_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    chk("flt_clr", {31'b0, fault}, 32'd0);
    chk("flt_bubble", {31'b0, instr_valid}, 32'd0);
    step(); chk_instr("flt_80", 32'h80);
    step(); chk_instr("flt_84", 32'h84);

    // Halt with held instruction and ready low
    instr_ready = 1'b0; halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_instr("hlt_hold", 32'h84);
    end
    instr_ready = 1'b1;
    step();
    chk("hlt_drain", {31'b0, instr_valid}, 32'd0);
    step();
    chk("hlt_idle", {31'b0, instr_valid}, 32'd0);
    chk("hlt_addr", imem_addr, 32'h88);
    halt = 1'b0;
    step(); chk_instr("hlt_88", 32'h88);

    // Wrap at top of address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap_bubble", {31'b0, instr_valid}, 32'd0);
    step(); chk_instr("wrap_top", 32'hFFFF_FFFC);
    step(); chk_instr("wrap_zero", 32'h0);
    chk("wrap_raw", instr, 32'h11);

    // Asynchronous reset mid-stream
    step(); chk_instr("pre_rst", 32'h4);
    rstn = 1'b0;
    #2;
    chk("arst_vld", {31'b0, instr_valid}, 32'd0);
    chk("arst_pc", instr_pc, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    #3 rstn = 1'b1;
    step(); chk_instr("arst_0", 32'h0);
    step(); chk_instr("arst_4", 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch controller that sequences the combinational instruction memory. It owns the fetch program counter, drives the memory address, and registers each returned word into a one-entry output stage with a valid/ready handshake toward decode. It also handles redirects (branch/jump), halt requests and misaligned-target faults. It sits between the core's control/execute stage and the instruction memory.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] ignored (treated as 0)
- clk_i  in  1  clock, all state updates on rising edge
- rstn_i  in  1  asynchronous, active-low reset
- imem_addr_o  out  32  fetch address to instruction memory; equals fetch_pc (combinational from register)
- imem_data_i  in  32  instruction word returned combinationally for imem_addr_o
- instr_o  out  32  registered instruction to decode
- instr_pc_o  out  32  address instr_o was fetched from
- instr_valid_o  out  1  instr_o/instr_pc_o hold a live instruction
- instr_ready_i  in  1  decode accepts instr_o this cycle
- redirect_i  in  1  control-flow change; flush and refetch
- redirect_pc_i  in  32  redirect target
- halt_i  in  1  suspend fetching while high
- fault_o  out  1  misaligned redirect target captured; fetch stopped
- fault_pc_o  out  32  offending redirect target

## Operation
- State register, 3 states: RUN, HALTED, FAULT.
- Internal fetch_pc register; imem_addr_o = fetch_pc at all times.
- Load condition: state RUN, halt_i low, redirect_i low, and (instr_valid_o low or instr_ready_i high).
- On load: instr_o <= imem_data_i, instr_pc_o <= fetch_pc, instr_valid_o <= 1, fetch_pc <= fetch_pc + 4.
- Handshake without load (ready high, no load condition): instr_valid_o <= 0.
- Valid held, ready low: instr_o, instr_pc_o, fetch_pc all hold; no refetch.
- Address arithmetic is modulo 2^32: fetch_pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- redirect_i high, redirect_pc_i[1:0] == 0:
  - fetch_pc <= redirect_pc_i; instr_valid_o <= 0 (flush).
  - Next state is RUN if halt_i is low, else HALTED.
  - A redirect in FAULT clears fault_o and leaves FAULT.
- redirect_i high, redirect_pc_i[1:0] != 0:
  - state <= FAULT; fault_o <= 1; fault_pc_o <= redirect_pc_i; instr_valid_o <= 0; fetch_pc unchanged.
- Priority per cycle: reset > redirect (aligned or misaligned) > halt > load.
- RUN -> HALTED when halt_i is high and no redirect.
  - The held instruction stays valid until accepted; no new load.
- HALTED -> RUN when halt_i is low. Loading resumes the same cycle halt_i is sampled low.
- FAULT: no loads; halt_i ignored. Exit only via an aligned redirect or reset.
- Simultaneous redirect and accepted handshake: the transfer counts as accepted, then the flush applies. Nothing further is presented from the old path.

## Timing
- Reset (async assert) values:
  - state = RUN, fetch_pc = RESET_PC & ~3
  - instr_valid_o = 0, instr_o = 0, instr_pc_o = 0
  - fault_o = 0, fault_pc_o = 0
- First rising edge after rstn_i deasserts loads the word at RESET_PC; instr_valid_o is high from then on.
- Steady state with ready held high: one instruction per cycle; instr_pc_o increments by 4 each cycle.
- Redirect latency: redirect_i sampled at edge N; imem_addr_o = target during cycle N+1; target instruction valid after edge N+1.
  - Exactly one bubble cycle with instr_valid_o low.
- Backpressure: outputs stable while instr_valid_o && !instr_ready_i. Required for protocol checks.
- fault_o asserts at the edge that samples the misaligned redirect.
- Reset asserted mid-operation: all outputs return to reset values immediately, independent of clock.

## Test plan
- Reset release, RESET_PC = 0, mem[0..3] = 11,22,33,44, ready high -> instr_o sequence 11,22,33,44 on consecutive cycles; instr_pc_o = 0,4,8,C.
- Ready low for 3 cycles while valid with instr_pc_o = 8 -> instr_o/instr_pc_o hold; imem_addr_o holds C; after ready rises, PCs continue C,10 with no skip or duplicate.
- Redirect to 0x40 during a cycle with ready high -> exactly one cycle with valid low, then instr_pc_o = 0x40, 0x44.
- Redirect to 0x42 -> fault_o = 1, fault_pc_o = 0x42, valid low indefinitely; halt_i toggles ignored; redirect to 0x80 -> fault_o = 0, instr_pc_o = 0x80 after one bubble.
- halt_i high for 4 cycles with valid set and ready low -> held instruction is accepted once ready rises, then valid stays low; halt_i low -> fetch resumes at the next sequential PC.
- Redirect to 0xFFFF_FFFC, ready high -> instr_pc_o = FFFF_FFFC then 0000_0000 (wrap).
- rstn_i pulsed low mid-stream -> outputs reset asynchronously; fetch restarts at RESET_PC.
